// File: rtl/or_nor_pkg.sv
// Shared types and sizes for the OR/NOR mux sweep controller.
// Imported by the controller, its reference model and the bench.
package or_nor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int VEC_COUNT = 8;
  localparam int IDX_W     = 3;
  localparam int ERR_W     = 4;

endpackage

// File: rtl/or_nor_sweep_ctrl_ref.sv
// Reference model of the OR/NOR select mux.
// r = sel ? ~(a|b) : (a|b).
module or_nor_ref (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic exp_o
);

  // Golden value for one {a,b,sel} vector
  always_comb exp_o = sel ? ~(a | b) : (a | b);

endmodule

// File: rtl/or_nor_sweep_ctrl.sv
// Drives all 8 {a,b,sel} vectors into the OR/NOR mux,
// samples r_in per vector and records mismatches.
module or_nor_sweep_ctrl
  import or_nor_pkg::*;
#(
  parameter int HOLD_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             r_in,
  output logic             a,
  output logic             b,
  output logic             sel,
  output logic             busy,
  output logic             done,
  output logic [ERR_W-1:0] err_cnt,
  output logic             fail_valid,
  output logic [IDX_W-1:0] first_fail_idx,
  output logic             expect_o
);

  localparam int HC_W =
    (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HC_W-1:0] HC_LAST =
    HC_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST =
    IDX_W'(VEC_COUNT - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             fail_valid_q, fail_valid_d;
  logic [IDX_W-1:0] ffi_q, ffi_d;
  logic             exp_w;

  or_nor_ref u_ref (
    .a     (idx_q[2]),
    .b     (idx_q[1]),
    .sel   (idx_q[0]),
    .exp_o (exp_w)
  );

  // Next-state, counter and capture logic
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    hold_cnt_d   = hold_cnt_q;
    err_cnt_d    = err_cnt_q;
    fail_valid_d = fail_valid_q;
    ffi_d        = ffi_q;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d      = DRIVE;
          idx_d        = '0;
          hold_cnt_d   = '0;
          err_cnt_d    = '0;
          fail_valid_d = 1'b0;
          ffi_d        = '0;
        end
      end
      DRIVE: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + HC_W'(1);
          if (hold_cnt_q == HC_LAST) begin
            if (r_in != exp_w) begin
              err_cnt_d = err_cnt_q + ERR_W'(1);
              if (!fail_valid_q) begin
                fail_valid_d = 1'b1;
                ffi_d        = idx_q;
              end
            end
            hold_cnt_d = '0;
            if (idx_q == IDX_LAST) begin
              state_d = DONE;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and result registers, synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      hold_cnt_q   <= '0;
      err_cnt_q    <= '0;
      fail_valid_q <= 1'b0;
      ffi_q        <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      hold_cnt_q   <= hold_cnt_d;
      err_cnt_q    <= err_cnt_d;
      fail_valid_q <= fail_valid_d;
      ffi_q        <= ffi_d;
    end
  end

  assign a              = idx_q[2];
  assign b              = idx_q[1];
  assign sel            = idx_q[0];
  assign busy           = (state_q == DRIVE);
  assign done           = (state_q == DONE);
  assign err_cnt        = err_cnt_q;
  assign fail_valid     = fail_valid_q;
  assign first_fail_idx = ffi_q;
  assign expect_o       = exp_w;

endmodule

// File: tb/tb_or_nor_sweep_ctrl.sv
// Directed bench for or_nor_sweep_ctrl, hold of 1 and 3.
// Vectors and expected results are hand-computed.
module tb_or_nor_sweep_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  logic       start1, abort1, r1;
  logic       a1, b1, s1, busy1, done1, fv1, exp1;
  logic [3:0] err1;
  logic [2:0] ffi1;
  logic [1:0] mode1;

  logic       start3, abort3, r3, flip3;
  logic       a3, b3, s3, busy3, done3, fv3, exp3;
  logic [3:0] err3;
  logic [2:0] ffi3;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_tab;

  always #5 clk = ~clk;

  // mode1: 0 = correct mux, 1 = r tied 0, 2 = r tied 1
  assign r1 = (mode1 == 2'd0) ? (s1 ? ~(a1 | b1) : (a1 | b1))
            : (mode1 == 2'd2);
  assign r3 = (s3 ? ~(a3 | b3) : (a3 | b3)) ^ flip3;

  or_nor_sweep_ctrl #(.HOLD_CYCLES(1)) dut1 (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start1),
    .abort          (abort1),
    .r_in           (r1),
    .a              (a1),
    .b              (b1),
    .sel            (s1),
    .busy           (busy1),
    .done           (done1),
    .err_cnt        (err1),
    .fail_valid     (fv1),
    .first_fail_idx (ffi1),
    .expect_o       (exp1)
  );

  or_nor_sweep_ctrl #(.HOLD_CYCLES(3)) dut3 (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start3),
    .abort          (abort3),
    .r_in           (r3),
    .a              (a3),
    .b              (b3),
    .sel            (s3),
    .busy           (busy3),
    .done           (done3),
    .err_cnt        (err3),
    .fail_valid     (fv3),
    .first_fail_idx (ffi3),
    .expect_o       (exp3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_res1(input string tag,
                          input logic [3:0] e,
                          input logic f,
                          input logic [2:0] i);
    chk({tag, "_err"}, {4'd0, err1}, {4'd0, e});
    chk({tag, "_fv"}, {7'd0, fv1}, {7'd0, f});
    chk({tag, "_ffi"}, {5'd0, ffi1}, {5'd0, i});
  endtask

  // Pulse start on dut1; returns in cycle 1 of the sweep
  task automatic go1();
    start1 = 1'b1;
    step();
    start1 = 1'b0;
  endtask

  initial begin
    exp_tab = 8'b0101_0110;
    rst_n  = 1'b0;
    start1 = 1'b0; abort1 = 1'b0; mode1 = 2'd0;
    start3 = 1'b0; abort3 = 1'b0; flip3 = 1'b0;
    step();
    step();

    chk("rst_abs", {5'd0, a1, b1, s1}, 8'd0);
    chk("rst_busy", {6'd0, busy1, done1}, 8'd0);
    chk_res1("rst", 4'd0, 1'b0, 3'd0);
    chk("rst3_busy", {6'd0, busy3, done3}, 8'd0);
    rst_n = 1'b1;
    step();

    // Correct mux, full walk with per-cycle checks
    go1();
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("walk_busy%0d", k), {7'd0, busy1}, 8'd1);
      chk($sformatf("walk_idx%0d", k),
          {5'd0, a1, b1, s1}, 8'(k));
      chk($sformatf("walk_exp%0d", k),
          {7'd0, exp1}, {7'd0, exp_tab[k]});
      chk($sformatf("walk_done%0d", k), {7'd0, done1}, 8'd0);
      step();
    end
    chk("walk_done", {6'd0, busy1, done1}, 8'd1);
    chk_res1("walk", 4'd0, 1'b0, 3'd0);
    step();
    chk("walk_done_off", {7'd0, done1}, 8'd0);
    chk("walk_hold_idx", {5'd0, a1, b1, s1}, 8'd7);

    // r tied 0
    mode1 = 2'd1;
    go1();
    repeat (8) step();
    chk("tie0_done", {7'd0, done1}, 8'd1);
    chk_res1("tie0", 4'd4, 1'b1, 3'd1);
    step();

    // r tied 1
    mode1 = 2'd2;
    go1();
    repeat (8) step();
    chk("tie1_done", {7'd0, done1}, 8'd1);
    chk_res1("tie1", 4'd4, 1'b1, 3'd0);
    step();
    chk_res1("tie1_held", 4'd4, 1'b1, 3'd0);

    // Restart with correct mux clears results
    mode1 = 2'd0;
    go1();
    chk_res1("restart_clr", 4'd0, 1'b0, 3'd0);
    repeat (8) step();
    chk("restart_done", {7'd0, done1}, 8'd1);
    chk_res1("restart", 4'd0, 1'b0, 3'd0);
    step();

    // Start in cycle 4 of a sweep is ignored
    go1();
    repeat (3) step();
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk("ign_idx", {5'd0, a1, b1, s1}, 8'd4);
    repeat (3) step();
    chk("ign_c8", {6'd0, busy1, done1}, 8'd2);
    step();
    chk("ign_c9", {6'd0, busy1, done1}, 8'd1);
    step();

    // Abort in cycle 5 with r tied 0
    mode1 = 2'd1;
    go1();
    repeat (4) step();
    abort1 = 1'b1;
    step();
    abort1 = 1'b0;
    chk("abort_idle", {6'd0, busy1, done1}, 8'd0);
    chk_res1("abort", 4'd2, 1'b1, 3'd1);
    chk("abort_idx", {5'd0, a1, b1, s1}, 8'd4);
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("abort_nodone%0d", k),
          {6'd0, busy1, done1}, 8'd0);
    end

    // Reset in cycle 5 of a sweep
    go1();
    repeat (4) step();
    chk("prerst_err", {4'd0, err1}, 8'd2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_abs", {5'd0, a1, b1, s1}, 8'd0);
    chk("midrst_bd", {6'd0, busy1, done1}, 8'd0);
    chk_res1("midrst", 4'd0, 1'b0, 3'd0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("midrst_nodone%0d", k),
          {6'd0, busy1, done1}, 8'd0);
    end

    // start with abort in IDLE stays IDLE
    start1 = 1'b1;
    abort1 = 1'b1;
    step();
    start1 = 1'b0;
    abort1 = 1'b0;
    chk("sa_busy", {6'd0, busy1, done1}, 8'd0);
    step();
    chk("sa_busy2", {6'd0, busy1, done1}, 8'd0);

    // Hold of 3, r wrong on first two cycles of every vector
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      flip3 = (((c - 1) % 3) < 2);
      chk($sformatf("h3_busy%0d", c), {7'd0, busy3}, 8'd1);
      chk($sformatf("h3_idx%0d", c),
          {5'd0, a3, b3, s3}, 8'((c - 1) / 3));
      step();
    end
    flip3 = 1'b0;
    chk("h3_done", {6'd0, busy3, done3}, 8'd1);
    chk("h3_err", {4'd0, err3}, 8'd0);
    chk("h3_fv", {7'd0, fv3}, 8'd0);
    step();
    chk("h3_done_off", {7'd0, done3}, 8'd0);

    // Hold of 3, r wrong on the sampling cycle of vector 5
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      flip3 = (c == 18);
      step();
    end
    flip3 = 1'b0;
    chk("h3b_done", {7'd0, done3}, 8'd1);
    chk("h3b_err", {4'd0, err3}, 8'd1);
    chk("h3b_fv", {7'd0, fv3}, 8'd1);
    chk("h3b_ffi", {5'd0, ffi3}, 8'd5);
    step();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
